bcd_countdown_timer: RTL and testbench

//  Multi-digit BCD countdown timer for the memory-tester game round clock.

---
 rtl/bcd_countdown_timer.sv | 144 ++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer for the game round clock: internal tick prescaler,
// pause/resume, optional auto-reload of the last loaded value, one-cycle expiry pulse.
module bcd_countdown_timer #(
   parameter int NUM_DIGITS  = 4,
   parameter int TICK_DIV    = 50000000,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    start,
   input  logic                    pause,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    running,
   output logic                    done,
   output logic                    expired
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  digits_q, digits_d;
   logic [W-1:0]  reload_q, reload_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          expired_q, expired_d;

   logic [W-1:0]  clamped;
   logic [W-1:0]  decremented;
   logic          dec_zero;
   logic          tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         digits_q  <= '0;
         reload_q  <= '0;
         pre_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         reload_q  <= reload_d;
         pre_q     <= pre_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      clamped = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
      end
   end

   // Digit 0 always takes the borrow; a zero digit becomes 9 and passes it upward.
   always_comb begin
      logic borrow;
      decremented = digits_q;
      borrow      = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               decremented[4*i +: 4] = 4'd9;
            end else begin
               decremented[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               borrow                = 1'b0;
            end
         end
      end
   end

   assign dec_zero = (decremented == '0);
   assign tick     = (pre_q == PRE_MAX);

   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      reload_d  = reload_q;
      pre_d     = pre_q;
      expired_d = 1'b0;
      if (load) begin
         digits_d = clamped;
         reload_d = clamped;
         pre_d    = '0;
         state_d  = S_IDLE;
      end else if (start) begin
         if (state_q == S_RUN) begin
            pre_d = '0;
         end else if (digits_q != '0) begin
            state_d = S_RUN;
            pre_d   = '0;
         end else begin
            state_d   = S_DONE;
            expired_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_RUN: begin
               if (pause) begin
                  state_d = S_PAUSED;
               end else if (tick) begin
                  pre_d = '0;
                  if (dec_zero) begin
                     expired_d = 1'b1;
                     if (AUTO_RELOAD && (reload_q != '0)) begin
                        digits_d = reload_q;
                     end else begin
                        digits_d = '0;
                        state_d  = S_DONE;
                     end
                  end else begin
                     digits_d = decremented;
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            S_PAUSED: begin
               if (!pause) state_d = S_RUN;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      digits  = digits_q;
      running = (state_q == S_RUN);
      done    = (state_q == S_DONE);
      expired = expired_q;
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random stimulus, with both
// AUTO_RELOAD variants checked every cycle against a decimal-arithmetic model.
module tb_bcd_countdown_timer;

   localparam int ND = 2;
   localparam int TD = 4;
   localparam int DW = 4 * ND;
   localparam int W  = DW + 3;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;
   localparam int M_DONE   = 3;

   logic          clk;
   logic          rst;
   logic          load;
   logic [DW-1:0] load_value;
   logic          start;
   logic          pause;
   logic [DW-1:0] digits0, digits1;
   logic          running0, running1;
   logic          done0, done1;
   logic          expired0, expired1;

   int total;
   int bad;

   // model state per instance: [0] no reload, [1] auto-reload
   int m_val[2];
   int m_rel[2];
   int m_ph[2];
   int m_mode[2];
   bit m_exp[2];

   logic [W-1:0] exp_q[$];

   bcd_countdown_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start),
      .pause(pause), .digits(digits0), .running(running0), .done(done0), .expired(expired0)
   );

   bcd_countdown_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start),
      .pause(pause), .digits(digits1), .running(running1), .done(done1), .expired(expired1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] to_bcd(input int v);
      logic [DW-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int clamp_val(input logic [DW-1:0] lv);
      int s;
      int p;
      int n;
      s = 0;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         n = int'(lv[4*i +: 4]);
         if (n > 9) n = 9;
         s = s + n * p;
         p = p * 10;
      end
      return s;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         m_exp[i] = 1'b0;
         if (rst) begin
            m_val[i]  = 0;
            m_rel[i]  = 0;
            m_ph[i]   = 0;
            m_mode[i] = M_IDLE;
         end else if (load) begin
            m_val[i]  = clamp_val(load_value);
            m_rel[i]  = m_val[i];
            m_ph[i]   = 0;
            m_mode[i] = M_IDLE;
         end else if (start) begin
            if (m_mode[i] == M_RUN) begin
               m_ph[i] = 0;
            end else if (m_val[i] != 0) begin
               m_mode[i] = M_RUN;
               m_ph[i]   = 0;
            end else begin
               m_mode[i] = M_DONE;
               m_exp[i]  = 1'b1;
            end
         end else if (m_mode[i] == M_RUN && pause) begin
            m_mode[i] = M_PAUSED;
         end else if (m_mode[i] == M_PAUSED && !pause) begin
            m_mode[i] = M_RUN;
         end else if (m_mode[i] == M_RUN) begin
            if (m_ph[i] == TD - 1) begin
               m_ph[i]  = 0;
               m_val[i] = m_val[i] - 1;
               if (m_val[i] == 0) begin
                  m_exp[i] = 1'b1;
                  if (i == 1 && m_rel[i] != 0) m_val[i] = m_rel[i];
                  else m_mode[i] = M_DONE;
               end
            end else begin
               m_ph[i] = m_ph[i] + 1;
            end
         end
         exp_q.push_back({to_bcd(m_val[i]), m_mode[i] == M_RUN, m_mode[i] == M_DONE, m_exp[i]});
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic compare();
      logic [W-1:0] e0, e1;
      if (exp_q.size() < 2) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty actual=%0d expected=2", exp_q.size());
      end else begin
         e0 = exp_q.pop_front();
         e1 = exp_q.pop_front();
         chk("model_dut0", 32'({digits0, running0, done0, expired0}), 32'(e0));
         chk("model_dut1", 32'({digits1, running1, done1, expired1}), 32'(e1));
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare();
      end
   endtask

   task automatic do_load(input logic [DW-1:0] v);
      load       = 1'b1;
      load_value = v;
      step(1);
      load       = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      load       = 1'b0;
      load_value = '0;
      start      = 1'b0;
      pause      = 1'b0;
      step(2);
      chk("reset_digits", 32'(digits0), 32'h0);
      chk("reset_flags", 32'({running0, done0, expired0}), 32'h0);
      rst = 1'b0;
      step(1);

      // 12 counts down to 00, one step every 4 clocks
      do_load(8'h12);
      chk("load_12", 32'(digits0), 32'h12);
      do_start();
      chk("start_running", 32'(running0), 32'h1);
      step(4);
      chk("first_step_11", 32'(digits0), 32'h11);
      step(44);
      chk("reach_zero", 32'({digits0, done0, expired0}), {22'h0, 8'h00, 2'b11});
      step(1);
      chk("expired_one_cycle", 32'({done0, expired0}), 32'b10);

      // clamp and zero start
      do_load(8'h3F);
      chk("clamp_39", 32'(digits0), 32'h39);
      do_load(8'h00);
      do_start();
      chk("zero_start", 32'({running0, done0, expired0}), 32'b011);

      // pause mid-count
      do_load(8'h05);
      do_start();
      step(6);
      pause = 1'b1;
      step(10);
      chk("paused_hold", 32'({digits0, running0}), {23'h0, 8'h04, 1'b0});
      pause = 1'b0;
      step(2);
      chk("resume_no_early", 32'(digits0), 32'h04);
      step(1);
      chk("resume_step", 32'(digits0), 32'h03);
      step(20);

      // auto-reload instance
      do_load(8'h02);
      do_start();
      step(4);
      chk("reload_01", 32'(digits1), 32'h01);
      step(4);
      chk("reload_back", 32'({digits1, running1, done1, expired1}), {21'h0, 8'h02, 3'b101});
      step(16);

      // reset mid-count
      do_load(8'h07);
      do_start();
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst_mid", 32'({digits0, running0, done0, expired0}), 32'h0);
      do_start();
      chk("start_after_rst", 32'({done0, expired0}), 32'b11);

      // load wins over start, then borrow ripple
      load       = 1'b1;
      start      = 1'b1;
      load_value = 8'h20;
      step(1);
      load  = 1'b0;
      start = 1'b0;
      chk("load_start", 32'({digits0, running0}), {23'h0, 8'h20, 1'b0});
      do_start();
      step(4);
      chk("borrow_19", 32'(digits0), 32'h19);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 299) == 0);
         load  = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 11) == 0) pause = ~pause;
         if ($urandom_range(0, 1) == 0) load_value = 8'($urandom_range(0, 3));
         else load_value = 8'($urandom_range(0, 255));
         step(1);
      end
      rst   = 1'b0;
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
